spi_subordinate_model: RTL and testbench

//  Parametrised SPI subordinate test model for HAL and bench tests. Covers all four SPI modes,
//  any word width and a host-readable receive FIFO. It sits on the manager's sclk/mosi/miso/cs
//  bus. MISO echoes the previous completed word, one frame late.

---
 rtl/spi_subordinate_model.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_subordinate_model.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_subordinate_model.sv
// ============================================================================
// Module      : spi_subordinate_model
// Description : SPI subordinate test model. Covers all four SPI modes and
//               keeps received words in a host-readable RX FIFO. MISO echoes
//               the previously completed word one frame later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_subordinate_model #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    CPOL         = 0,
    parameter int                    CPHA         = 0,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            sclk,
    input  logic                            mosi,
    input  logic                            cs,
    output logic                            miso,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            rx_valid,
    input  logic                            rx_pop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_level,
    output logic                            overflow,
    output logic [15:0]                     frame_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic             SCLK_IDLE = (CPOL != 0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e                state_q,       state_d;
    logic                  sclk_meta_q,   sclk_meta_d;
    logic                  sclk_s_q,      sclk_s_d;
    logic                  sclk_prev_q,   sclk_prev_d;
    logic                  mosi_meta_q,   mosi_meta_d;
    logic                  mosi_s_q,      mosi_s_d;
    logic                  cs_meta_q,     cs_meta_d;
    logic                  cs_s_q,        cs_s_d;
    logic                  cs_prev_q,     cs_prev_d;
    logic [CNT_W-1:0]      bit_cnt_q,     bit_cnt_d;
    logic                  first_q,       first_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,    rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,    tx_shift_d;
    logic [DATA_WIDTH-1:0] echo_q,        echo_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
    logic [LVL_W-1:0]      count_q,       count_d;
    logic                  overflow_q,    overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_cs_fall;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_write;

    assign w_rise    = sclk_s_q & ~sclk_prev_q;
    assign w_fall    = ~sclk_s_q & sclk_prev_q;
    assign w_lead    = (CPOL != 0) ? w_fall : w_rise;
    assign w_trail   = (CPOL != 0) ? w_rise : w_fall;
    assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
    assign w_shift   = (CPHA != 0) ? w_lead  : w_trail;
    assign w_cs_fall = cs_prev_q & ~cs_s_q;
    assign w_word    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s_q};

    always_comb begin
        state_d       = state_q;
        sclk_meta_d   = sclk;
        sclk_s_d      = sclk_meta_q;
        sclk_prev_d   = sclk_s_q;
        mosi_meta_d   = mosi;
        mosi_s_d      = mosi_meta_q;
        cs_meta_d     = cs;
        cs_s_d        = cs_meta_q;
        cs_prev_d     = cs_s_q;
        bit_cnt_d     = bit_cnt_q;
        first_d       = first_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        echo_d        = echo_q;
        frame_count_d = frame_count_q;
        w_push        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    state_d    = ST_ACTIVE;
                    tx_shift_d = echo_q;
                    bit_cnt_d  = '0;
                    first_d    = 1'b1;
                end
            end
            default: begin
                if (cs_s_q) begin
                    // Any partial word is simply abandoned here.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (w_sample) begin
                    rx_shift_d = w_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        w_push        = 1'b1;
                        echo_d        = w_word;
                        frame_count_d = frame_count_q + 16'd1;
                        bit_cnt_d     = '0;
                        first_d       = 1'b1;
                        // Next back-to-back frame must carry the word just completed.
                        tx_shift_d    = w_word;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        first_d   = 1'b0;
                    end
                end else if (w_shift) begin
                    // The first shift edge of a frame must not disturb the freshly loaded MSB.
                    if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is only lost without one.
    assign w_pop   = rx_pop & (count_q != '0);
    assign w_full  = (count_q == FULL_LVL);
    assign w_write = w_push & (~w_full | w_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (w_push && !w_write) begin
            overflow_d = 1'b1;
        end
        if (w_write) begin
            mem_d[wr_ptr_q] = w_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_write && !w_pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (!w_write && w_pop) begin
            count_d = count_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            sclk_meta_q   <= SCLK_IDLE;
            sclk_s_q      <= SCLK_IDLE;
            sclk_prev_q   <= SCLK_IDLE;
            mosi_meta_q   <= 1'b1;
            mosi_s_q      <= 1'b1;
            cs_meta_q     <= 1'b1;
            cs_s_q        <= 1'b1;
            cs_prev_q     <= 1'b1;
            bit_cnt_q     <= '0;
            first_q       <= 1'b1;
            rx_shift_q    <= '0;
            tx_shift_q    <= IDLE_PATTERN;
            echo_q        <= IDLE_PATTERN;
            frame_count_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_meta_q   <= sclk_meta_d;
            sclk_s_q      <= sclk_s_d;
            sclk_prev_q   <= sclk_prev_d;
            mosi_meta_q   <= mosi_meta_d;
            mosi_s_q      <= mosi_s_d;
            cs_meta_q     <= cs_meta_d;
            cs_s_q        <= cs_s_d;
            cs_prev_q     <= cs_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            first_q       <= first_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            echo_q        <= echo_d;
            frame_count_q <= frame_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign miso        = cs_s_q ? 1'bz : tx_shift_q[DATA_WIDTH-1];
    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_valid    = (count_q != '0);
    assign rx_level    = count_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_subordinate_model.sv
// ============================================================================
// Module      : tb_spi_subordinate_model
// Description : Directed bench for spi_subordinate_model in all four modes
//               and a 16-bit configuration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_subordinate_model;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mosi;
    logic [4:0]  sclk_v;
    logic [4:0]  cs_v;
    logic [4:0]  pop_v;
    wire  [4:0]  miso_v;
    logic [4:0]  valid_v;
    logic [4:0]  ovf_v;
    logic [2:0]  lvl [5];
    logic [15:0] fc [5];
    logic [7:0]  rxd8 [4];
    logic [15:0] rxd16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instances 0..3 are 8-bit modes 0..3; instance 4 is 16-bit mode 3.
    spi_subordinate_model #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .FIFO_DEPTH(4)) u_m0 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk_v[0]), .mosi(mosi), .cs(cs_v[0]),
        .miso(miso_v[0]), .rx_data(rxd8[0]), .rx_valid(valid_v[0]), .rx_pop(pop_v[0]),
        .rx_level(lvl[0]), .overflow(ovf_v[0]), .frame_count(fc[0]));
    spi_subordinate_model #(.DATA_WIDTH(8), .CPOL(0), .CPHA(1), .FIFO_DEPTH(4)) u_m1 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk_v[1]), .mosi(mosi), .cs(cs_v[1]),
        .miso(miso_v[1]), .rx_data(rxd8[1]), .rx_valid(valid_v[1]), .rx_pop(pop_v[1]),
        .rx_level(lvl[1]), .overflow(ovf_v[1]), .frame_count(fc[1]));
    spi_subordinate_model #(.DATA_WIDTH(8), .CPOL(1), .CPHA(0), .FIFO_DEPTH(4)) u_m2 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk_v[2]), .mosi(mosi), .cs(cs_v[2]),
        .miso(miso_v[2]), .rx_data(rxd8[2]), .rx_valid(valid_v[2]), .rx_pop(pop_v[2]),
        .rx_level(lvl[2]), .overflow(ovf_v[2]), .frame_count(fc[2]));
    spi_subordinate_model #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .FIFO_DEPTH(4)) u_m3 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk_v[3]), .mosi(mosi), .cs(cs_v[3]),
        .miso(miso_v[3]), .rx_data(rxd8[3]), .rx_valid(valid_v[3]), .rx_pop(pop_v[3]),
        .rx_level(lvl[3]), .overflow(ovf_v[3]), .frame_count(fc[3]));
    spi_subordinate_model #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1), .FIFO_DEPTH(4)) u_m4 (
        .clock(clk), .reset_n(reset_n), .sclk(sclk_v[4]), .mosi(mosi), .cs(cs_v[4]),
        .miso(miso_v[4]), .rx_data(rxd16), .rx_valid(valid_v[4]), .rx_pop(pop_v[4]),
        .rx_level(lvl[4]), .overflow(ovf_v[4]), .frame_count(fc[4]));

    function automatic bit cpol_of(input int idx);
        return (idx >= 2);
    endfunction

    function automatic bit cpha_of(input int idx);
        return (idx == 1) || (idx >= 3);
    endfunction

    function automatic logic [15:0] rx_of(input int idx);
        if (idx == 4) return rxd16;
        return {8'h00, rxd8[idx]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sclk_v  = 5'b11100;
        cs_v    = 5'b11111;
        pop_v   = 5'b00000;
        mosi    = 1'b0;
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic pop(input int idx);
        pop_v[idx] = 1'b1;
        wait_clk(1);
        pop_v[idx] = 1'b0;
        wait_clk(1);
    endtask

    // Manager side: drives nbits of data MSB first and returns what miso carried.
    task automatic xfer(input int idx, input int w, input int nbits, input logic [15:0] data,
                        input bit start_cs, input bit end_cs, input bit pop_last,
                        output logic [15:0] got);
        bit pol;
        bit pha;
        pol = cpol_of(idx);
        pha = cpha_of(idx);
        got = '0;
        if (start_cs) begin
            cs_v[idx] = 1'b0;
            wait_clk(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            if (!pha) begin
                mosi = data[w-1-i];
                wait_clk(HALF);
                got = {got[14:0], miso_v[idx]};
                sclk_v[idx] = ~pol;
            end else begin
                sclk_v[idx] = ~pol;
                mosi = data[w-1-i];
                wait_clk(HALF);
                got = {got[14:0], miso_v[idx]};
                sclk_v[idx] = pol;
            end
            // Line the pop up with the cycle the completing sample edge reaches the FIFO.
            if (pop_last && i == nbits - 1) begin
                wait_clk(2);
                pop_v[idx] = 1'b1;
                wait_clk(1);
                pop_v[idx] = 1'b0;
                wait_clk(HALF - 3);
            end else begin
                wait_clk(HALF);
            end
            if (!pha) sclk_v[idx] = pol;
        end
        if (!pha) wait_clk(HALF);
        if (end_cs) begin
            cs_v[idx] = 1'b1;
            wait_clk(HALF);
        end
    endtask

    initial begin
        logic [15:0] g;
        logic [7:0]  pat_a;
        logic [7:0]  pat_b;

        do_reset();
        check_eq("rst_level", 32'(lvl[0]), 0);
        check_eq("rst_valid", 32'(valid_v[0]), 0);
        check_eq("rst_ovf", 32'(ovf_v[0]), 0);
        check_eq("rst_fc", 32'(fc[0]), 0);

        // Mode 0 basic echo and FIFO order
        xfer(0, 8, 8, 16'h00A5, 1'b1, 1'b1, 1'b0, g);
        check_eq("m0_miso1", 32'(g), 32'h00FF);
        xfer(0, 8, 8, 16'h003C, 1'b1, 1'b1, 1'b0, g);
        check_eq("m0_miso2", 32'(g), 32'h00A5);
        check_eq("m0_fc", 32'(fc[0]), 2);
        check_eq("m0_level", 32'(lvl[0]), 2);
        check_eq("m0_rx1", 32'(rx_of(0)), 32'h00A5);
        pop(0);
        check_eq("m0_rx2", 32'(rx_of(0)), 32'h003C);
        pop(0);
        check_eq("m0_empty", 32'(valid_v[0]), 0);

        // Modes 1..3
        for (int m = 1; m <= 3; m++) begin
            xfer(m, 8, 8, 16'h0081, 1'b1, 1'b1, 1'b0, g);
            check_eq($sformatf("m%0d_miso1", m), 32'(g), 32'h00FF);
            xfer(m, 8, 8, 16'h007E, 1'b1, 1'b1, 1'b0, g);
            check_eq($sformatf("m%0d_miso2", m), 32'(g), 32'h0081);
            check_eq($sformatf("m%0d_rx1", m), 32'(rx_of(m)), 32'h0081);
            pop(m);
            check_eq($sformatf("m%0d_rx2", m), 32'(rx_of(m)), 32'h007E);
            pop(m);
            check_eq($sformatf("m%0d_fc", m), 32'(fc[m]), 2);
        end

        // Aborted partial frame leaves no trace
        xfer(0, 8, 5, 16'h00FF, 1'b1, 1'b1, 1'b0, g);
        check_eq("abort_level", 32'(lvl[0]), 0);
        check_eq("abort_fc", 32'(fc[0]), 2);
        xfer(0, 8, 8, 16'h005A, 1'b1, 1'b1, 1'b0, g);
        check_eq("abort_echo", 32'(g), 32'h003C);
        check_eq("abort_rx", 32'(rx_of(0)), 32'h005A);
        check_eq("abort_fc2", 32'(fc[0]), 3);

        // Overflow on a full FIFO without pops
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            xfer(0, 8, 8, 16'(k), 1'b1, 1'b1, 1'b0, g);
        end
        check_eq("ovf_level", 32'(lvl[0]), 4);
        check_eq("ovf_flag", 32'(ovf_v[0]), 1);
        check_eq("ovf_fc", 32'(fc[0]), 5);
        for (int k = 1; k <= 4; k++) begin
            check_eq($sformatf("ovf_pop%0d", k), 32'(rx_of(0)), k);
            pop(0);
        end
        check_eq("ovf_sticky", 32'(ovf_v[0]), 1);

        // Full FIFO with a pop in the push cycle
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            xfer(0, 8, 8, 16'(k * 17), 1'b1, 1'b1, 1'b0, g);
        end
        check_eq("pp_full", 32'(lvl[0]), 4);
        xfer(0, 8, 8, 16'h0055, 1'b1, 1'b1, 1'b1, g);
        check_eq("pp_ovf", 32'(ovf_v[0]), 0);
        check_eq("pp_level", 32'(lvl[0]), 4);
        for (int k = 2; k <= 5; k++) begin
            check_eq($sformatf("pp_pop%0d", k), 32'(rx_of(0)), k * 17);
            pop(0);
        end

        // 16-bit mode 3, cs held low across two frames
        xfer(4, 16, 16, 16'h1234, 1'b1, 1'b0, 1'b0, g);
        check_eq("w16_miso1", 32'(g), 32'hFFFF);
        xfer(4, 16, 16, 16'hBEEF, 1'b0, 1'b1, 1'b0, g);
        check_eq("w16_miso2", 32'(g), 32'h1234);
        check_eq("w16_level", 32'(lvl[4]), 2);
        check_eq("w16_rx1", 32'(rx_of(4)), 32'h1234);
        pop(4);
        check_eq("w16_rx2", 32'(rx_of(4)), 32'hBEEF);
        pop(4);

        // Reset in the middle of a frame
        do_reset();
        pat_a = 8'h96;
        xfer(0, 8, 8, 16'(pat_a), 1'b1, 1'b1, 1'b0, g);
        check_eq("mr_pre_level", 32'(lvl[0]), 1);
        xfer(0, 8, 3, 16'h00F0, 1'b1, 1'b0, 1'b0, g);
        reset_n = 1'b0;
        wait_clk(1);
        check_eq("mr_level", 32'(lvl[0]), 0);
        check_eq("mr_valid", 32'(valid_v[0]), 0);
        check_eq("mr_ovf", 32'(ovf_v[0]), 0);
        check_eq("mr_fc", 32'(fc[0]), 0);
        cs_v[0] = 1'b1;
        sclk_v[0] = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        pat_b = 8'hC3;
        xfer(0, 8, 8, 16'(pat_b), 1'b1, 1'b1, 1'b0, g);
        check_eq("mr_echo", 32'(g), 32'h00FF);
        check_eq("mr_rx", 32'(rx_of(0)), 32'h00C3);
        check_eq("mr_fc2", 32'(fc[0]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
